udp_seq_eval: RTL and testbench

Hardware evaluator for a programmed sequential user-defined primitive with N_IN inputs and one registered output. A loader writes the primitive's state table row by row. The engine then accepts input vectors, matches them against the table in table order using level and edge symbols, and produces the next output state. The block is the table reader and executor for the primitive definitions that the parser flow declares and instantiates; emulation and equivalence harnesses use it.

---
 rtl/udp_seq_eval.sv | 211 +++++++++++++++++++++
 tb/tb_udp_seq_eval.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_seq_eval.sv
// Sequential UDP evaluator: a loader fills the primitive's state table row by row,
// then each accepted input vector is matched against the rows in order.
module udp_seq_eval #(
   parameter int N_IN = 2,
   parameter int DEPTH = 16,
   parameter logic [1:0] INIT = 2'b01,
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int ROW_W = 4 * N_IN + 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [ROW_W-1:0]    load_data,
   input  logic                load_last,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*N_IN-1:0]   in_vals,
   output logic                out_valid,
   output logic [1:0]          out,
   output logic                matched,
   output logic [IDX_W-1:0]    match_idx,
   output logic                load_err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [1:0] VAL_X = 2'b10;

   typedef enum logic [1:0] {EMPTY, READY, SCAN} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    row_count_q, row_count_d;
   logic [CNT_W-1:0]    scan_q, scan_d;
   logic [2*N_IN-1:0]   cur_q, cur_d;
   logic [2*N_IN-1:0]   prv_q, prv_d;
   logic [1:0]          out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic                matched_q, matched_d;
   logic [IDX_W-1:0]    match_idx_q, match_idx_d;
   logic                load_err_q, load_err_d;

   logic [ROW_W-1:0]    table_mem [DEPTH];
   logic                tbl_we;
   logic [ROW_W-1:0]    row;
   logic [N_IN-1:0]     changed;
   logic [3:0]          edge_cnt;
   logic [2:0]          edge_pos;
   logic                lvl_ok, edge_ok, st_ok, in_range, row_hit;
   logic [1:0]          next_code;

   function automatic logic level_match(input logic [3:0] sym, input logic [1:0] v);
      logic r;
      case (sym)
         4'd0:    r = (v == 2'b00);
         4'd1:    r = (v == 2'b01);
         4'd2:    r = (v == VAL_X);
         4'd3:    r = (v != 2'b11);
         4'd4:    r = (v[1] == 1'b0);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_edge(input logic [3:0] sym);
      return (sym >= 4'd8) && (sym <= 4'd12);
   endfunction

   function automatic logic edge_match(input logic [3:0] sym, input logic [1:0] p,
                                       input logic [1:0] c);
      logic r;
      case (sym)
         4'd8:    r = (p == 2'b00) && (c == 2'b01);
         4'd9:    r = (p == 2'b01) && (c == 2'b00);
         4'd10:   r = ((p == 2'b00) && ((c == 2'b01) || (c == VAL_X))) ||
                      ((p == VAL_X) && (c == 2'b01));
         4'd11:   r = ((p == 2'b01) && ((c == 2'b00) || (c == VAL_X))) ||
                      ((p == VAL_X) && (c == 2'b00));
         4'd12:   r = (p != c);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (tbl_we) table_mem[wr_ptr_q[IDX_W-1:0]] <= load_data;
   end

   // An edge row fires only when its own input is the sole input that changed.
   always_comb begin
      row       = table_mem[scan_q[IDX_W-1:0]];
      in_range  = (scan_q < row_count_q);
      edge_cnt  = '0;
      edge_pos  = '0;
      lvl_ok    = 1'b1;
      edge_ok   = 1'b0;
      changed   = '0;
      for (int i = 0; i < N_IN; i++) begin
         changed[i] = (cur_q[2*i +: 2] != prv_q[2*i +: 2]);
         if (is_edge(row[4*i +: 4])) begin
            edge_cnt = edge_cnt + 4'd1;
            edge_pos = 3'(i);
            edge_ok  = edge_match(row[4*i +: 4], prv_q[2*i +: 2], cur_q[2*i +: 2]);
         end else if (!level_match(row[4*i +: 4], cur_q[2*i +: 2])) begin
            lvl_ok = 1'b0;
         end
      end
      st_ok     = level_match({1'b0, row[ROW_W-1 -: 3]}, out_q);
      next_code = row[4*N_IN +: 2];
      case (edge_cnt)
         4'd0:    row_hit = in_range && lvl_ok && st_ok;
         4'd1:    row_hit = in_range && lvl_ok && st_ok && edge_ok &&
                            (changed == (N_IN'(1) << edge_pos));
         default: row_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      row_count_d = row_count_q;
      load_err_d  = load_err_q;
      scan_d      = scan_q;
      cur_d       = cur_q;
      prv_d       = prv_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      matched_d   = matched_q;
      match_idx_d = match_idx_q;
      tbl_we      = 1'b0;
      load_ready  = (state_q != SCAN);
      in_ready    = (state_q == READY);

      if (load_valid && load_ready) begin
         if (wr_ptr_q < CNT_W'(DEPTH)) begin
            tbl_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
         end else begin
            load_err_d = 1'b1;
         end
         if (load_last) begin
            row_count_d = (wr_ptr_q < CNT_W'(DEPTH)) ? wr_ptr_q + CNT_W'(1) : CNT_W'(DEPTH);
            wr_ptr_d    = '0;
            if (state_q == EMPTY) state_d = READY;
         end
      end

      case (state_q)
         READY: begin
            if (in_valid) begin
               cur_d   = in_vals;
               prv_d   = cur_q;
               scan_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (row_hit) begin
               out_valid_d = 1'b1;
               matched_d   = 1'b1;
               match_idx_d = scan_q[IDX_W-1:0];
               out_d       = (next_code == 2'b11) ? out_q : next_code;
               state_d     = READY;
            end else if (!in_range || (scan_q + CNT_W'(1) >= row_count_q)) begin
               out_valid_d = 1'b1;
               matched_d   = 1'b0;
               out_d       = VAL_X;
               state_d     = READY;
            end else begin
               scan_d = scan_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         wr_ptr_q    <= '0;
         row_count_q <= '0;
         load_err_q  <= 1'b0;
         scan_q      <= '0;
         cur_q       <= {N_IN{VAL_X}};
         prv_q       <= {N_IN{VAL_X}};
         out_q       <= INIT;
         out_valid_q <= 1'b0;
         matched_q   <= 1'b0;
         match_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         row_count_q <= row_count_d;
         load_err_q  <= load_err_d;
         scan_q      <= scan_d;
         cur_q       <= cur_d;
         prv_q       <= prv_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         matched_q   <= matched_d;
         match_idx_q <= match_idx_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign matched   = matched_q;
   assign match_idx = match_idx_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_udp_seq_eval.sv
// Scoreboard bench for udp_seq_eval: inverter, D flop, overflow, reload and
// mid-scan reset scenarios with hand-derived expected results and latencies.
module tb_udp_seq_eval;

   localparam int N_IN = 2;
   localparam int DEPTH = 4;
   localparam logic [1:0] INIT = 2'b01;
   localparam int ROW_W = 4 * N_IN + 5;

   localparam int S0 = 0, S1 = 1, SX = 2, SQ = 3, SR = 8, SF = 9, SS = 12;
   localparam int NX0 = 0, NX1 = 1, NXX = 2, NXK = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_valid = 1'b0;
   logic load_last = 1'b0;
   logic in_valid = 1'b0;
   logic [ROW_W-1:0] load_data = '0;
   logic [2*N_IN-1:0] in_vals = '0;
   logic load_ready, in_ready, out_valid, matched, load_err;
   logic [1:0] out;
   logic [1:0] match_idx;

   typedef struct {
      logic [1:0] out;
      bit         m;
      int         idx;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tb_rows = 0;
   logic [ROW_W-1:0] rows [8];

   udp_seq_eval #(.N_IN(N_IN), .DEPTH(DEPTH), .INIT(INIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_last(load_last),
      .in_valid(in_valid), .in_ready(in_ready), .in_vals(in_vals),
      .out_valid(out_valid), .out(out), .matched(matched), .match_idx(match_idx),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [ROW_W-1:0] mk_row(input int st, input int nx, input int s1,
                                               input int s0);
      return {3'(st), 2'(nx), 4'(s1), 4'(s0)};
   endfunction

   function automatic logic [3:0] iv(input logic [1:0] in0, input logic [1:0] in1);
      return {in1, in0};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Each result pulse is retired against the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("out", 32'(out), 32'(e.out));
            checkOutput("matched", 32'(matched), 32'(e.m));
            if (e.m) checkOutput("match_idx", 32'(match_idx), 32'(e.idx));
            checkOutput("result_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic waitIdle();
      int w = 0;
      while (sb_q.size() != 0 && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      if (sb_q.size() != 0) begin
         checkOutput("result_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   task automatic loadTable(input int n, input bit chk_ready);
      for (int i = 0; i < n; i++) begin
         int w = 0;
         while (!load_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
         end
         if (!load_ready) checkOutput("load_ready_timeout", 32'd0, 32'd1);
         load_valid = 1'b1;
         load_data  = rows[i];
         load_last  = (i == n - 1);
         if (chk_ready) checkOutput("in_ready_during_load", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] vals, input logic [1:0] e_out, input bit e_m,
                                input int e_idx);
      exp_t e;
      int w = 0;
      while (!in_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
      in_vals  = vals;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("in_ready_scan", 32'(in_ready), 32'd0);
      checkOutput("load_ready_scan", 32'(load_ready), 32'd0);
      e.out = e_out;
      e.m   = e_m;
      e.idx = e_idx;
      e.cyc = cyc + (e_m ? 1 + e_idx : tb_rows);
      sb_q.push_back(e);
      waitIdle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out", 32'(out), 32'(INIT));
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_matched", 32'(matched), 32'd0);
      checkOutput("rst_match_idx", 32'(match_idx), 32'd0);
      checkOutput("rst_load_err", 32'(load_err), 32'd0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("in_ready_empty", 32'(in_ready), 32'd0);

      // Inverter on input 0, input 1 ignored.
      rows[0] = mk_row(SQ, NX1, SQ, S0);
      rows[1] = mk_row(SQ, NX0, SQ, S1);
      loadTable(2, 1'b0);
      tb_rows = 2;
      checkOutput("in_ready_loaded", 32'(in_ready), 32'd1);
      applyStimulus(iv(2'b00, 2'b00), 2'b01, 1'b1, 0);
      applyStimulus(iv(2'b01, 2'b00), 2'b00, 1'b1, 1);

      // D flop reloaded while READY: input 0 = d, input 1 = clk.
      rows[0] = mk_row(SQ, NX0, SR, S0);
      rows[1] = mk_row(SQ, NX1, SR, S1);
      rows[2] = mk_row(SQ, NXK, SF, SQ);
      rows[3] = mk_row(SQ, NXK, S0, SS);
      loadTable(4, 1'b1);
      tb_rows = 4;
      applyStimulus(iv(2'b01, 2'b00), 2'b10, 1'b0, 0);
      applyStimulus(iv(2'b01, 2'b01), 2'b01, 1'b1, 1);
      applyStimulus(iv(2'b01, 2'b00), 2'b01, 1'b1, 2);
      applyStimulus(iv(2'b00, 2'b00), 2'b01, 1'b1, 3);
      applyStimulus(iv(2'b01, 2'b01), 2'b10, 1'b0, 0);
      applyStimulus(iv(2'b00, 2'b00), 2'b10, 1'b0, 0);
      applyStimulus(iv(2'b00, 2'b01), 2'b00, 1'b1, 0);

      // Six beats into a four-row table: the last two must be dropped.
      checkOutput("load_err_before", 32'(load_err), 32'd0);
      rows[0] = mk_row(SQ, NX0, S1, S1);
      rows[1] = mk_row(SQ, NX1, S1, S0);
      rows[2] = mk_row(SQ, NXX, SQ, SX);
      rows[3] = mk_row(S0, NX1, S0, S0);
      rows[4] = mk_row(SQ, NX1, S0, S1);
      rows[5] = mk_row(SQ, NX0, S0, S1);
      loadTable(6, 1'b1);
      tb_rows = 4;
      checkOutput("load_err_overflow", 32'(load_err), 32'd1);
      applyStimulus(iv(2'b01, 2'b00), 2'b10, 1'b0, 0);
      applyStimulus(iv(2'b01, 2'b01), 2'b00, 1'b1, 0);
      applyStimulus(iv(2'b00, 2'b00), 2'b01, 1'b1, 3);
      applyStimulus(iv(2'b00, 2'b01), 2'b01, 1'b1, 1);
      checkOutput("load_err_sticky", 32'(load_err), 32'd1);

      // Reset in the middle of a four-row scan.
      in_vals  = iv(2'b01, 2'b00);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out", 32'(out), 32'(INIT));
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_load_err", 32'(load_err), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("midrst_load_ready", 32'(load_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("in_ready_after_reset", 32'(in_ready), 32'd0);
      checkOutput("out_after_reset", 32'(out), 32'(INIT));

      rows[0] = mk_row(S1, NX0, SQ, SQ);
      loadTable(1, 1'b0);
      tb_rows = 1;
      checkOutput("in_ready_reloaded", 32'(in_ready), 32'd1);
      applyStimulus(iv(2'b01, 2'b01), 2'b00, 1'b1, 0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
